hqm_rcfwl_gclk_rlink_sync_rcvr: RTL and testbench
=================================================

// Module: hqm_rcfwl_gclk_rlink_sync_rcvr
// PURPOSE
//  Receive end of the rlink clock-spine/pll_sync distribution. Samples the
//  distributed pll_sync pulse train and checks its period. Acquires lock, then
//  flywheels a phase counter. Emits sync-aligned divided clock enables,
//  error pulses and a count. Sits in each logicphy partition beside the clkdist leaf.
// PARAMETERS
//  SYNC_PERIOD  16  clk cycles between pll_sync rising edges; >=4
//  DIV_RATIO    4   ce_out period in clk cycles; must divide SYNC_PERIOD
//  LOCK_COUNT   3   consecutive good periods needed to lock; >=1
//  ERR_THRESH   2   consecutive bad periods, while locked, that drop lock; >=1
//  ERR_W        8   width of saturating err_cnt
// PORTS
//  clk           in  1      spine clock (ckpredop of clkdist leaf)
//  rst_b         in  1      async active-low reset
//  pll_sync_in   in  1      distributed sync, synchronous to clk, level/pulse
//  sync_en       in  1      0: force ACQUIRE, all status outputs inactive
//  err_clr       in  1      sync clear of err_cnt
//  pll_sync_out  out 1      pll_sync_in retimed by 1 flop, for next hop
//  sync_locked   out 1      FSM in LOCKED
//  phase         out clog2(SYNC_PERIOD)  position within sync period
//  ce_out        out 1      divided clock enable
//  sync_err      out 1      1-cycle pulse per detected bad period (LOCKED only)
//  err_cnt       out ERR_W  saturating bad-period count
// BEHAVIOUR
//  Reset: all flops 0, FSM=ACQUIRE; all outputs 0.
//  sync_q <= pll_sync_in; sync_q_d <= sync_q; pll_sync_out = sync_q.
//  rise = sync_q & ~sync_q_d (first cycle of a high level; long levels = one rise).
//  per_cnt: set to 0 on rise or on 'miss', else +1 saturating at all-ones.
//  Per cycle, using pre-update per_cnt: good = rise & per_cnt==SYNC_PERIOD-1;
//   early = rise & per_cnt<SYNC_PERIOD-1; miss = ~rise & per_cnt==SYNC_PERIOD-1.
//   good and miss are mutually exclusive (rise exactly on boundary = good).
//  FSM (enum in pkg):
//   ACQUIRE: rise -> CHECK, good_cnt=0, phase=1 next cycle (rise cycle = phase 0).
//     Ignores per_cnt checks.
//   CHECK: good -> good_cnt+1; on reaching LOCK_COUNT -> LOCKED.
//     early -> stay CHECK, good_cnt=0, phase realigned.
//     miss -> ACQUIRE. No sync_err/err_cnt in CHECK.
//   LOCKED: good -> bad_cnt=0. early|miss -> sync_err=1 next cycle, err_cnt+1
//     (saturate), bad_cnt+1; if bad_cnt+1==ERR_THRESH -> ACQUIRE, bad_cnt=0.
//   sync_en=0 any cycle -> ACQUIRE next cycle, counters except err_cnt cleared.
//  phase: in CHECK/LOCKED, phase wraps SYNC_PERIOD-1 -> 0 every cycle. Realigns to
//   0 on rise only in CHECK (LOCKED flywheels; early rise does not move phase).
//   phase=0 in ACQUIRE.
//  sync_locked = (state==LOCKED), registered state, no extra delay.
//  ce_out = sync_locked & (phase % DIV_RATIO == 0). Decoded from flops only.
//  err_clr & new error same cycle -> err_cnt=1. err_clr alone -> 0.
//  Async reset mid-lock: immediate return to reset values, relock from scratch.
// STRUCTURE
//  Package hqm_rcfwl_gclk_rlink_pkg holds:
//   - rlink_sync_state_t {ACQUIRE,CHECK,LOCKED}
//   - a clog2-based phase-width localparam function.
//  Sub-module hqm_rcfwl_gclk_rlink_sync_edge: input retime flops and rise
//   detect; outputs sync_q and rise.
//  Top: per_cnt, FSM, phase, err logic.
//  Elaboration assert: SYNC_PERIOD % DIV_RATIO == 0.
// TESTING (defaults)
//  1. Rise detected cycle T, then rises at T+16/32/48 -> sync_locked=1 at T+49.
//     After lock, ce_out at phase 0,4,8,12; pll_sync_out lags input by 1.
//  2. Locked, one sync suppressed -> miss at boundary, sync_err 1 cycle,
//     err_cnt=1. Next good rise -> still locked. Two consecutive misses ->
//     sync_locked=0 after 2nd.
//  3. Locked, rise 5 cycles early -> sync_err, phase unchanged (flywheel).
//     A subsequent on-time period (relative to the early rise) -> bad_cnt cleared.
//  4. In CHECK after 2 good periods, early rise -> good_cnt=0. Lock needs 3
//     further good periods from that rise.
//  5. pll_sync held high 8 cycles -> counted as one rise. err_cnt at 255,
//     more errors -> stays 255. err_clr with error same cycle -> err_cnt=1.
//  6. rst_b low mid-LOCKED -> all outputs 0 asynchronously. sync_en=0 one
//     cycle -> ACQUIRE, err_cnt retained.

Source files
------------

// File: rtl/hqm_rcfwl_gclk_rlink_pkg.sv
// Shared types for the rlink pll_sync receive path.
package hqm_rcfwl_gclk_rlink_pkg;

   typedef enum logic [1:0] {
      ACQUIRE,
      CHECK,
      LOCKED
   } rlink_sync_state_t;

   function automatic int phase_w(input int period);
      return (period > 2) ? $clog2(period) : 1;
   endfunction

endpackage

// File: rtl/hqm_rcfwl_gclk_rlink_sync_edge.sv
// Retimes the distributed pll_sync and flags the first cycle of each high level.
module hqm_rcfwl_gclk_rlink_sync_edge (
   input  logic clk,
   input  logic rst_b,
   input  logic pll_sync_in,
   output logic sync_q,
   output logic rise
);

   logic sync_q_d;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         sync_q   <= 1'b0;
         sync_q_d <= 1'b0;
      end else begin
         sync_q   <= pll_sync_in;
         sync_q_d <= sync_q;
      end
   end

   assign rise = sync_q & ~sync_q_d;

endmodule

// File: rtl/hqm_rcfwl_gclk_rlink_sync_rcvr.sv
// rlink pll_sync receiver: period check, lock FSM, flywheel phase,
// divided clock enable and saturating error count.
module hqm_rcfwl_gclk_rlink_sync_rcvr
   import hqm_rcfwl_gclk_rlink_pkg::*;
#(
   parameter int SYNC_PERIOD = 16,
   parameter int DIV_RATIO   = 4,
   parameter int LOCK_COUNT  = 3,
   parameter int ERR_THRESH  = 2,
   parameter int ERR_W       = 8,
   localparam int PW         = phase_w(SYNC_PERIOD)
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             pll_sync_in,
   input  logic             sync_en,
   input  logic             err_clr,
   output logic             pll_sync_out,
   output logic             sync_locked,
   output logic [PW-1:0]    phase,
   output logic             ce_out,
   output logic             sync_err,
   output logic [ERR_W-1:0] err_cnt
);

   localparam int GW = $clog2(LOCK_COUNT + 1);
   localparam int BW = $clog2(ERR_THRESH + 1);
   localparam logic [PW-1:0] PER_LAST = PW'(SYNC_PERIOD - 1);
   localparam logic [GW-1:0] GOOD_LIM = GW'(LOCK_COUNT);
   localparam logic [BW-1:0] BAD_LIM  = BW'(ERR_THRESH);

   if ((SYNC_PERIOD % DIV_RATIO) != 0 || SYNC_PERIOD < 4
       || LOCK_COUNT < 1 || ERR_THRESH < 1) begin : g_bad_cfg
      $error("hqm_rcfwl_gclk_rlink_sync_rcvr: illegal parameters");
   end

   rlink_sync_state_t state;
   logic [PW-1:0] per_cnt;
   logic [PW-1:0] per_sat;
   logic [PW-1:0] phase_inc;
   logic [GW-1:0] good_cnt;
   logic [GW-1:0] good_nxt;
   logic [BW-1:0] bad_cnt;
   logic [BW-1:0] bad_nxt;
   logic sync_q;
   logic rise;
   logic good;
   logic early;
   logic miss;
   logic new_err;
   logic ce_hit;

   hqm_rcfwl_gclk_rlink_sync_edge u_edge (
      .clk         (clk),
      .rst_b       (rst_b),
      .pll_sync_in (pll_sync_in),
      .sync_q      (sync_q),
      .rise        (rise)
   );

   assign pll_sync_out = sync_q;

   assign good  = rise & (per_cnt == PER_LAST);
   assign early = rise & (per_cnt < PER_LAST);
   assign miss  = ~rise & (per_cnt == PER_LAST);

   assign per_sat   = (per_cnt == '1) ? per_cnt : per_cnt + 1'b1;
   assign phase_inc = (phase == PER_LAST) ? '0 : phase + 1'b1;
   assign good_nxt  = good_cnt + 1'b1;
   assign bad_nxt   = bad_cnt + 1'b1;

   assign new_err = sync_en & (state == LOCKED) & (early | miss);

   assign sync_locked = (state == LOCKED);
   assign ce_hit      = ((32'(phase) % 32'(DIV_RATIO)) == 32'd0);
   assign ce_out      = sync_locked & ce_hit;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state    <= ACQUIRE;
         per_cnt  <= '0;
         good_cnt <= '0;
         bad_cnt  <= '0;
         phase    <= '0;
         sync_err <= 1'b0;
         err_cnt  <= '0;
      end else begin
         sync_err <= new_err;
         per_cnt  <= (rise | miss) ? '0 : per_sat;

         // a clear coinciding with a fresh error keeps that error
         if (err_clr)
            err_cnt <= new_err ? ERR_W'(1) : '0;
         else if (new_err && err_cnt != '1)
            err_cnt <= err_cnt + 1'b1;

         if (!sync_en) begin
            state    <= ACQUIRE;
            per_cnt  <= '0;
            good_cnt <= '0;
            bad_cnt  <= '0;
            phase    <= '0;
         end else begin
            unique case (state)
               ACQUIRE: begin
                  if (rise) begin
                     state    <= CHECK;
                     good_cnt <= '0;
                     phase    <= PW'(1);
                  end
               end
               CHECK: begin
                  phase <= rise ? PW'(1) : phase_inc;
                  if (miss) begin
                     state    <= ACQUIRE;
                     good_cnt <= '0;
                     phase    <= '0;
                  end else if (early) begin
                     good_cnt <= '0;
                  end else if (good) begin
                     good_cnt <= good_nxt;
                     if (good_nxt == GOOD_LIM) begin
                        state    <= LOCKED;
                        good_cnt <= '0;
                     end
                  end
               end
               LOCKED: begin
                  // flywheel: an early rise is an error, not a realign
                  phase <= phase_inc;
                  if (good) begin
                     bad_cnt <= '0;
                  end else if (early | miss) begin
                     bad_cnt <= bad_nxt;
                     if (bad_nxt == BAD_LIM) begin
                        state   <= ACQUIRE;
                        bad_cnt <= '0;
                        phase   <= '0;
                     end
                  end
               end
               default: state <= ACQUIRE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_hqm_rcfwl_gclk_rlink_sync_rcvr.sv
// Directed bench for the rlink pll_sync receiver at default parameters.
module tb_hqm_rcfwl_gclk_rlink_sync_rcvr;

   logic       clk;
   logic       rst_b;
   logic       pll_sync_in;
   logic       sync_en;
   logic       err_clr;
   logic       pll_sync_out;
   logic       sync_locked;
   logic [3:0] phase;
   logic       ce_out;
   logic       sync_err;
   logic [7:0] err_cnt;

   int n_pass;
   int n_fail;
   int n_total;

   hqm_rcfwl_gclk_rlink_sync_rcvr dut (
      .clk          (clk),
      .rst_b        (rst_b),
      .pll_sync_in  (pll_sync_in),
      .sync_en      (sync_en),
      .err_clr      (err_clr),
      .pll_sync_out (pll_sync_out),
      .sync_locked  (sync_locked),
      .phase        (phase),
      .ce_out       (ce_out),
      .sync_err     (sync_err),
      .err_cnt      (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input logic s);
      pll_sync_in = s;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b0);
   endtask

   task automatic sync_period(input int hi, input int len);
      repeat (hi) tick(1'b1);
      repeat (len - hi) tick(1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_pass = 0;
      n_fail = 0;
      n_total = 0;
      rst_b = 1'b0;
      pll_sync_in = 1'b0;
      sync_en = 1'b1;
      err_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_locked", 32'(sync_locked), 0);
      chk("rst_phase", 32'(phase), 0);
      chk("rst_ce", 32'(ce_out), 0);
      chk("rst_err", 32'(sync_err), 0);
      chk("rst_cnt", 32'(err_cnt), 0);
      chk("rst_pso", 32'(pll_sync_out), 0);
      rst_b = 1'b1;
      idle(3);

      // acquisition: first rise at T, locked at T+49
      tick(1'b1);
      chk("pso_rise", 32'(pll_sync_out), 1);
      chk("acq_phase", 32'(phase), 0);
      tick(1'b0);
      chk("pso_lag", 32'(pll_sync_out), 0);
      chk("chk_phase1", 32'(phase), 1);
      chk("chk_unlocked", 32'(sync_locked), 0);
      idle(14);
      sync_period(1, 16);
      sync_period(1, 16);
      tick(1'b1);
      chk("lock_t48", 32'(sync_locked), 0);
      tick(1'b0);
      chk("lock_t49", 32'(sync_locked), 1);
      chk("lock_phase", 32'(phase), 1);
      chk("ce_ph1", 32'(ce_out), 0);
      idle(3);
      chk("ce_ph4_phase", 32'(phase), 4);
      chk("ce_ph4", 32'(ce_out), 1);
      tick(1'b0);
      chk("ce_ph5", 32'(ce_out), 0);
      idle(10);

      // suppressed sync while locked
      sync_period(1, 16);
      tick(1'b0);
      chk("miss_pre", 32'(sync_err), 0);
      tick(1'b0);
      chk("miss_err", 32'(sync_err), 1);
      chk("miss_cnt", 32'(err_cnt), 1);
      chk("miss_locked", 32'(sync_locked), 1);
      tick(1'b0);
      chk("miss_pulse1", 32'(sync_err), 0);
      idle(13);
      sync_period(1, 16);
      chk("recov_locked", 32'(sync_locked), 1);
      idle(17);
      chk("miss2a_locked", 32'(sync_locked), 1);
      chk("miss2a_cnt", 32'(err_cnt), 2);
      tick(1'b0);
      chk("miss2b_unlock", 32'(sync_locked), 0);
      chk("miss2b_err", 32'(sync_err), 1);
      chk("miss2b_cnt", 32'(err_cnt), 3);

      // early rise in CHECK restarts the good-period count
      idle(3);
      sync_period(1, 16);
      sync_period(1, 16);
      sync_period(1, 11);
      tick(1'b1);
      tick(1'b0);
      chk("early_chk_phase", 32'(phase), 1);
      chk("early_chk_lock", 32'(sync_locked), 0);
      chk("early_chk_noerr", 32'(sync_err), 0);
      chk("early_chk_cnt", 32'(err_cnt), 3);
      idle(14);
      sync_period(1, 16);
      chk("relock_e31", 32'(sync_locked), 0);
      sync_period(1, 16);
      chk("relock_e47", 32'(sync_locked), 0);
      tick(1'b1);
      tick(1'b0);
      chk("relock_e49", 32'(sync_locked), 1);
      idle(14);

      // early rise while locked: error, phase flywheels
      sync_period(1, 11);
      tick(1'b1);
      tick(1'b0);
      chk("early_lk_err", 32'(sync_err), 1);
      chk("early_lk_cnt", 32'(err_cnt), 4);
      chk("early_lk_lock", 32'(sync_locked), 1);
      chk("early_lk_phase", 32'(phase), 12);
      idle(14);
      tick(1'b1);
      idle(16);
      tick(1'b0);
      chk("badclr_err", 32'(sync_err), 1);
      chk("badclr_cnt", 32'(err_cnt), 5);
      chk("badclr_lock", 32'(sync_locked), 1);
      chk("badclr_phase", 32'(phase), 12);

      // saturate err_cnt with alternating good/miss periods
      for (int i = 0; i < 250; i++) begin
         idle(14);
         tick(1'b1);
         idle(17);
      end
      chk("sat_cnt", 32'(err_cnt), 255);
      chk("sat_lock", 32'(sync_locked), 1);
      idle(14);
      repeat (8) tick(1'b1);
      idle(10);
      chk("sat_hold_cnt", 32'(err_cnt), 255);
      chk("long_err", 32'(sync_err), 1);
      chk("long_lock", 32'(sync_locked), 1);

      // clear coinciding with an error
      idle(14);
      tick(1'b1);
      idle(16);
      err_clr = 1'b1;
      tick(1'b0);
      err_clr = 1'b0;
      chk("clr_err_cnt", 32'(err_cnt), 1);
      chk("clr_err_pulse", 32'(sync_err), 1);

      // sync_en drop keeps err_cnt
      sync_en = 1'b0;
      tick(1'b0);
      sync_en = 1'b1;
      chk("en_unlock", 32'(sync_locked), 0);
      chk("en_phase", 32'(phase), 0);
      chk("en_cnt", 32'(err_cnt), 1);
      err_clr = 1'b1;
      tick(1'b0);
      err_clr = 1'b0;
      chk("clr_alone", 32'(err_cnt), 0);

      // relock then async reset mid-lock
      sync_period(1, 16);
      sync_period(1, 16);
      sync_period(1, 16);
      tick(1'b1);
      tick(1'b0);
      chk("en_relock", 32'(sync_locked), 1);
      idle(3);
      chk("pre_rst_ce", 32'(ce_out), 1);
      #2;
      rst_b = 1'b0;
      #1;
      chk("arst_locked", 32'(sync_locked), 0);
      chk("arst_phase", 32'(phase), 0);
      chk("arst_ce", 32'(ce_out), 0);
      chk("arst_err", 32'(sync_err), 0);
      chk("arst_pso", 32'(pll_sync_out), 0);
      @(posedge clk);
      #1;
      rst_b = 1'b1;
      idle(2);
      sync_period(1, 16);
      sync_period(1, 16);
      sync_period(1, 16);
      tick(1'b1);
      chk("arst_relock_pre", 32'(sync_locked), 0);
      tick(1'b0);
      chk("arst_relock", 32'(sync_locked), 1);
      chk("arst_relock_ph", 32'(phase), 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
